// File: rtl/rram_responder_if.sv
// Controller-side bus of the RRAM responder: strobes, word address, error pulse and busy.
// The serial data line stays a plain inout pad on the responder itself.
interface rram_responder_if #(
    parameter int unsigned ADDR_W = 3
) ();
    logic              rram_ce;
    logic              rram_we;
    logic              rram_re;
    logic [ADDR_W-1:0] rram_addr;
    logic              rram_err;
    logic              busy;

    modport master (
        output rram_ce, rram_we, rram_re, rram_addr,
        input  rram_err, busy
    );

    modport slave (
        input  rram_ce, rram_we, rram_re, rram_addr,
        output rram_err, busy
    );
endinterface

// File: rtl/rram_responder.sv
// RRAM word-array responder: bit-serial 32-bit write/read bursts, LSB first, on one data pad.
// Define RRAM_FORMING_EN to require an all-ones forming write before a word becomes usable.
module rram_responder #(
    parameter int unsigned ADDR_W = 3
) (
    input  logic            clk,
    input  logic            CE_L,
    rram_responder_if.slave bus,
    inout  wire             rram_data
);
    localparam int unsigned Words = 1 << ADDR_W;

    typedef enum logic [1:0] {StIdle, StWr, StRd} state_e;

    state_e            state_q, state_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wr_sh_q, wr_sh_d;
    logic [31:0]       mem_q [Words];
    logic              err_q, err_d;
    logic              illegal;
    logic              commit;
    logic              wr_ok;
    logic              rd_bit;
    logic              drive;
    logic [31:0]       commit_word;

    assign illegal     = bus.rram_ce & bus.rram_we & bus.rram_re;
    // Bit 31 is taken straight off the pad so the word lands on the same edge.
    assign commit_word = {rram_data, wr_sh_q[30:0]};

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        addr_d    = addr_q;
        wr_sh_d   = wr_sh_q;
        err_d     = 1'b0;
        commit    = 1'b0;
        if (!bus.rram_ce) begin
            state_d   = StIdle;
            bit_cnt_d = '0;
        end else if (illegal) begin
            state_d   = StIdle;
            bit_cnt_d = '0;
            err_d     = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.rram_we) begin
                        state_d = StWr;
                        addr_d  = bus.rram_addr;
                    end else if (bus.rram_re) begin
                        state_d = StRd;
                        addr_d  = bus.rram_addr;
                    end
                end
                StWr: begin
                    if (bus.rram_re) begin
                        // Direction switch abandons the partial word without an error.
                        state_d   = StRd;
                        bit_cnt_d = '0;
                        addr_d    = bus.rram_addr;
                    end else begin
                        wr_sh_d[bit_cnt_q] = rram_data;
                        bit_cnt_d          = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd31) begin
                            commit = 1'b1;
                            addr_d = bus.rram_addr;
                        end
                    end
                end
                StRd: begin
                    if (bus.rram_we) begin
                        state_d   = StWr;
                        bit_cnt_d = '0;
                        addr_d    = bus.rram_addr;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd31) begin
                            addr_d = bus.rram_addr;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

`ifdef RRAM_FORMING_EN
    logic [Words-1:0] formed_q;

    // An unformed word only accepts the all-ones forming pattern.
    assign wr_ok  = formed_q[addr_q] | (&commit_word);
    assign rd_bit = formed_q[addr_q] & mem_q[addr_q][bit_cnt_q];

    always_ff @(posedge clk or negedge CE_L) begin
        if (!CE_L) begin
            formed_q <= '0;
        end else if (commit && wr_ok) begin
            formed_q[addr_q] <= 1'b1;
        end
    end
`else
    assign wr_ok  = 1'b1;
    assign rd_bit = mem_q[addr_q][bit_cnt_q];
`endif

    always_ff @(posedge clk or negedge CE_L) begin
        if (!CE_L) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            addr_q    <= '0;
            wr_sh_q   <= '0;
            err_q     <= 1'b0;
            for (int unsigned i = 0; i < Words; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            addr_q    <= addr_d;
            wr_sh_q   <= wr_sh_d;
            err_q     <= err_d | (commit & ~wr_ok);
            if (commit && wr_ok) begin
                mem_q[addr_q] <= commit_word;
            end
        end
    end

    assign drive         = (state_q == StRd) & bus.rram_ce & bus.rram_re & ~bus.rram_we;
    assign rram_data     = drive ? rd_bit : 1'bz;
    assign bus.rram_err  = err_q;
    assign bus.busy      = (state_q != StIdle);
endmodule

// File: tb/tb_rram_responder.sv
// Randomized transaction-level bench for rram_responder against a word-array reference model.
// The data pad is pulled up, so a released (high-Z) line reads back as 1.
module tb_rram_responder;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned WORDS  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic CE_L;
    logic tb_drv;
    logic tb_bit;
    wire  rram_data;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] model_mem    [WORDS];
    bit          model_formed [WORDS];

    rram_responder_if #(.ADDR_W(ADDR_W)) bus ();

    assign rram_data = tb_drv ? tb_bit : 1'bz;
    pullup (rram_data);

    rram_responder #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .CE_L      (CE_L),
        .bus       (bus),
        .rram_data (rram_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < WORDS; i++) begin
            model_mem[i]    = '0;
            model_formed[i] = 1'b0;
        end
    endfunction

    // Returns the error pulse the burst is expected to raise.
    function automatic logic model_write(input int a, input logic [31:0] d);
`ifdef RRAM_FORMING_EN
        if (!model_formed[a]) begin
            if (d != 32'hFFFF_FFFF) return 1'b1;
            model_formed[a] = 1'b1;
        end
`endif
        model_mem[a] = d;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_read(input int a);
`ifdef RRAM_FORMING_EN
        if (!model_formed[a]) return 32'h0;
`endif
        return model_mem[a];
    endfunction

    task automatic end_burst();
        bus.rram_ce = 1'b0;
        bus.rram_we = 1'b0;
        bus.rram_re = 1'b0;
        tb_drv      = 1'b0;
        @(negedge clk);
    endtask

    task automatic write_enter(input int a);
        bus.rram_ce   = 1'b1;
        bus.rram_we   = 1'b1;
        bus.rram_re   = 1'b0;
        bus.rram_addr = ADDR_W'(a);
        tb_drv        = 1'b0;
        @(negedge clk);
        check_eq("busy_wr", 32'(bus.busy), 32'd1);
    endtask

    task automatic write_stream(input logic [31:0] d, input int nbits, output logic err_seen);
        for (int i = 0; i < nbits; i++) begin
            tb_drv = 1'b1;
            tb_bit = d[i];
            @(negedge clk);
        end
        tb_drv   = 1'b0;
        err_seen = bus.rram_err;
    endtask

    task automatic read_enter(input int a);
        bus.rram_ce   = 1'b1;
        bus.rram_we   = 1'b0;
        bus.rram_re   = 1'b1;
        bus.rram_addr = ADDR_W'(a);
        tb_drv        = 1'b0;
        @(negedge clk);
    endtask

    task automatic read_stream(output logic [31:0] w);
        for (int i = 0; i < 32; i++) begin
            if (i > 0) @(negedge clk);
            w[i] = rram_data;
        end
    endtask

    task automatic do_write(input int a, input logic [31:0] d);
        logic e;
        write_enter(a);
        write_stream(d, 32, e);
        end_burst();
        check_eq("wr_err", 32'(e), 32'(model_write(a, d)));
    endtask

    task automatic do_read(input int a, output logic [31:0] w);
        read_enter(a);
        read_stream(w);
        check_eq("rd_err", 32'(bus.rram_err), 32'd0);
        end_burst();
        check_eq("rd_data", w, model_read(a));
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] d;
        logic        e;
        int          a;
        int          b;
        int          k;
        int          op;

        CE_L          = 1'b0;
        bus.rram_ce   = 1'b0;
        bus.rram_we   = 1'b0;
        bus.rram_re   = 1'b0;
        bus.rram_addr = '0;
        tb_drv        = 1'b0;
        tb_bit        = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_err", 32'(bus.rram_err), 32'd0);
        check_eq("rst_hiz", 32'(rram_data), 32'd1);
        CE_L = 1'b1;
        @(negedge clk);

        // Fresh array reads back zero.
        do_read(0, w);
        check_eq("rd0_zero", w, 32'h0);

`ifdef RRAM_FORMING_EN
        do_write(3, 32'hFFFF_FFFF);
`endif
        do_write(3, 32'hA5A5_0F0F);
        do_read(3, w);
        check_eq("rd3_pattern", w, 32'hA5A5_0F0F);

        // Burst aborted by ce drop after 20 bits leaves the old word.
        do_write(2, 32'h0BAD_F00D);
        write_enter(2);
        write_stream(32'h1357_9BDF, 20, e);
        end_burst();
        do_read(2, w);

        // we&re&ce mid-write: single error pulse, back to idle, no commit.
        do_write(4, 32'h5555_AAAA);
        write_enter(4);
        write_stream(32'hDEAD_BEEF, 10, e);
        bus.rram_re = 1'b1;
        @(negedge clk);
        check_eq("ill_err", 32'(bus.rram_err), 32'd1);
        check_eq("ill_busy", 32'(bus.busy), 32'd0);
        end_burst();
        check_eq("ill_err_end", 32'(bus.rram_err), 32'd0);
        do_read(4, w);

`ifdef RRAM_FORMING_EN
        do_write(1, 32'h1234_5678);
        do_read(1, w);
        check_eq("form_unformed", w, 32'h0);
        do_write(1, 32'hFFFF_FFFF);
        do_read(1, w);
        check_eq("form_ones", w, 32'hFFFF_FFFF);
        do_write(1, 32'h1234_5678);
        do_read(1, w);
        check_eq("form_data", w, 32'h1234_5678);
`endif

        for (int n = 0; n < 60; n++) begin
            op = int'($urandom_range(0, 4));
            a  = int'($urandom_range(0, WORDS - 1));
            b  = int'($urandom_range(0, WORDS - 1));
            k  = int'($urandom_range(1, 31));
            d  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            case (op)
                0: do_write(a, d);
                1: do_read(a, w);
                2: begin
                    write_enter(a);
                    write_stream(d, k, e);
                    end_burst();
                    check_eq("abort_busy", 32'(bus.busy), 32'd0);
                end
                3: begin
                    // Write switched to read: partial word dropped, read of b follows.
                    write_enter(a);
                    write_stream(d, k, e);
                    bus.rram_we   = 1'b0;
                    bus.rram_re   = 1'b1;
                    bus.rram_addr = ADDR_W'(b);
                    @(negedge clk);
                    read_stream(w);
                    check_eq("sw_rd_err", 32'(bus.rram_err), 32'd0);
                    end_burst();
                    check_eq("sw_rd_data", w, model_read(b));
                end
                default: begin
                    // Read switched to write: full word then lands at b.
                    read_enter(a);
                    repeat (k) @(negedge clk);
                    bus.rram_re   = 1'b0;
                    bus.rram_we   = 1'b1;
                    bus.rram_addr = ADDR_W'(b);
                    @(negedge clk);
                    write_stream(d, 32, e);
                    end_burst();
                    check_eq("sw_wr_err", 32'(e), 32'(model_write(b, d)));
                end
            endcase
        end

        // Reset in the middle of a read releases the pad and clears the array.
        do_write(5, 32'h0000_0000);
        d = model_read(5);
        read_enter(5);
        repeat (10) @(negedge clk);
        check_eq("rd_bit10", 32'(rram_data), 32'(d[10]));
        #2;
        CE_L = 1'b0;
        #1;
        check_eq("rst_mid_hiz", 32'(rram_data), 32'd1);
        check_eq("rst_mid_busy", 32'(bus.busy), 32'd0);
        end_burst();
        CE_L = 1'b1;
        model_reset();
        @(negedge clk);
        do_read(5, w);
        do_read(3, w);
        check_eq("rst_rd3_zero", w, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
